// File: rtl/ks_adder_arbiter_if.sv
// Requester/response bundle for ks_adder_arbiter: packed per-requester
// operands and grants, plus the shared tagged result port.
interface ks_adder_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*64-1:0] req_a;
  logic [NREQ*64-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [63:0]        rsp_sum;
  logic               rsp_cout;
  logic               busy;

  modport master (
    output req_valid, req_lock, req_a, req_b, req_cin,
    input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );

  modport slave (
    input  req_valid, req_lock, req_a, req_b, req_cin,
    output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
  );
endinterface

// File: rtl/ks_adder_arbiter.sv
// Round-robin (with optional burst lock) arbiter sharing one 64-bit
// Kogge-Stone adder; fixed 2-cycle latency, results tagged with requester id.
module ks_adder_64 (
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);
  logic [63:0] gk, pk, gn, pn;

  // Six prefix levels (span 1,2,4,...,32); gk/pk end as group G/P over [i:0].
  always_comb begin
    gk = a & b;
    pk = a ^ b;
    gn = '0;
    pn = '0;
    for (int unsigned l = 0; l < 6; l++) begin
      gn = gk;
      pn = pk;
      for (int unsigned i = 0; i < 64; i++) begin
        if (i >= (32'd1 << l)) begin
          gn[i] = gk[i] | (pk[i] & gk[i - (32'd1 << l)]);
          pn[i] = pk[i] & pk[i - (32'd1 << l)];
        end
      end
      gk = gn;
      pk = pn;
    end
    sum  = (a ^ b) ^ {gk[62:0] | (pk[62:0] & {63{cin}}), cin};
    cout = gk[63] | (pk[63] & cin);
  end
endmodule

module ks_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ks_adder_arbiter_if.slave bus
);
  localparam int unsigned N = NREQ;

  logic [IDW-1:0]  ptr;
  logic            lock_vld;
  logic [IDW-1:0]  lock_idx;

  logic            s1_valid;
  logic [63:0]     s1_a, s1_b;
  logic            s1_cin;
  logic [IDW-1:0]  s1_id;

  logic            s2_valid;
  logic [63:0]     s2_sum;
  logic            s2_cout;
  logic [IDW-1:0]  s2_id;

  logic [NREQ-1:0] grant;
  logic            found, lock_hit, hs, lock_next;
  logic [IDW-1:0]  gid, ptr_next;
  logic [63:0]     sel_a, sel_b;
  logic            sel_cin;
  logic [63:0]     add_sum;
  logic            add_cout;
  int unsigned     ptr_u, own_u;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    lock_hit = 1'b0;
    ptr_u    = 32'(ptr);
    own_u    = 32'(lock_idx);
    for (int unsigned i = 0; i < N; i++) begin
      if (lock_vld && i == own_u && bus.req_valid[i]) lock_hit = 1'b1;
    end
    if (lock_hit) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (i == own_u) grant[i] = 1'b1;
      end
    end else begin
      // Scan ptr, ptr+1, ... modulo N; first valid requester wins.
      for (int unsigned k = 0; k < N; k++) begin
        for (int unsigned i = 0; i < N; i++) begin
          if (!found && i == (ptr_u + k) % N && bus.req_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end
    if (!rst_n) grant = '0;
  end

  always_comb begin
    gid       = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_cin   = 1'b0;
    lock_next = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) begin
        gid       = IDW'(i);
        sel_a     = bus.req_a[i*64 +: 64];
        sel_b     = bus.req_b[i*64 +: 64];
        sel_cin   = bus.req_cin[i];
        lock_next = bus.req_lock[i];
      end
    end
    hs       = |grant;
    ptr_next = IDW'((32'(gid) + 32'd1) % N);
  end

  ks_adder_64 u_add (
    .a    (s1_a),
    .b    (s1_b),
    .cin  (s1_cin),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // A cycle without a handshake always clears the lock: either no lock was
  // held or its owner has just dropped req_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr      <= '0;
      lock_vld <= 1'b0;
      lock_idx <= '0;
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cin   <= 1'b0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_sum   <= '0;
      s2_cout  <= 1'b0;
      s2_id    <= '0;
    end else begin
      s1_valid <= hs;
      lock_vld <= hs & lock_next;
      if (hs) begin
        s1_a     <= sel_a;
        s1_b     <= sel_b;
        s1_cin   <= sel_cin;
        s1_id    <= gid;
        ptr      <= ptr_next;
        lock_idx <= gid;
      end
      s2_valid <= s1_valid;
      s2_sum   <= add_sum;
      s2_cout  <= add_cout;
      s2_id    <= s1_id;
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = s2_valid;
  assign bus.rsp_id    = s2_id;
  assign bus.rsp_sum   = s2_sum;
  assign bus.rsp_cout  = s2_cout;
  assign bus.busy      = s1_valid | s2_valid;
endmodule

// File: tb/tb_ks_adder_arbiter.sv
// Self-checking bench for ks_adder_arbiter: vector table, directed arbitration
// sequences and random traffic against a queue-based reference model.
module tb_ks_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ks_adder_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

  ks_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          due;
    int          id;
    logic [63:0] sum;
    logic        cout;
  } exp_t;

  typedef struct {
    int          rq;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
  } vec_t;

  exp_t q[$];
  vec_t tbl[5];
  int   nchk = 0, nerr = 0;
  int   cyc = 0;
  int   ptr_m = 0, lock_m = -1;

  logic [NREQ-1:0] smp_ready;
  logic            smp_valid, smp_cout, smp_busy;
  logic [IDW-1:0]  smp_id;
  logic [63:0]     smp_sum;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  function automatic int model_grant();
    if (lock_m >= 0 && bus.req_valid[lock_m]) return lock_m;
    for (int k = 0; k < NREQ; k++)
      if (bus.req_valid[(ptr_m + k) % NREQ]) return (ptr_m + k) % NREQ;
    return -1;
  endfunction

  // One clock cycle: check combinational grant and registered outputs at the
  // falling edge, then advance the model at the rising edge.
  task automatic step();
    int              g;
    logic [NREQ-1:0] er;
    logic [64:0]     full;
    exp_t            e;
    @(negedge clk);
    g  = model_grant();
    er = '0;
    if (rst_n && g >= 0) er[g] = 1'b1;
    smp_ready = bus.req_ready;
    smp_valid = bus.rsp_valid;
    smp_id    = bus.rsp_id;
    smp_sum   = bus.rsp_sum;
    smp_cout  = bus.rsp_cout;
    smp_busy  = bus.busy;
    chk("req_ready", 64'(smp_ready), 64'(er));
    chk("busy", 64'(smp_busy), 64'(q.size() != 0));
    if (q.size() != 0 && q[0].due == cyc) begin
      chk("rsp_valid", 64'(smp_valid), 64'd1);
      chk("rsp_id", 64'(smp_id), 64'(q[0].id));
      chk("rsp_sum", smp_sum, q[0].sum);
      chk("rsp_cout", 64'(smp_cout), 64'(q[0].cout));
      void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", 64'(smp_valid), 64'd0);
    end
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      ptr_m  = 0;
      lock_m = -1;
    end else if (g >= 0) begin
      full   = 65'(bus.req_a[g*64 +: 64]) + 65'(bus.req_b[g*64 +: 64]) + 65'(bus.req_cin[g]);
      e.due  = cyc + 2;
      e.id   = g;
      e.sum  = full[63:0];
      e.cout = full[64];
      q.push_back(e);
      ptr_m  = (g + 1) % NREQ;
      lock_m = bus.req_lock[g] ? g : -1;
    end else begin
      lock_m = -1;
    end
    cyc++;
    #1;
  endtask

  task automatic set_op(input int i, input logic [63:0] a, input logic [63:0] b, input logic cin);
    bus.req_a[i*64 +: 64] = a;
    bus.req_b[i*64 +: 64] = b;
    bus.req_cin[i]        = cin;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_lock  = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;

    tbl[0] = '{2, 64'd5, 64'd7, 1'b1, 64'd13, 1'b0};
    tbl[1] = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
    tbl[2] = '{3, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    tbl[3] = '{1, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    tbl[4] = '{2, 64'h0000_0000_FFFF_FFFF, 64'd1, 1'b1, 64'h0000_0001_0000_0001, 1'b0};

    #1;
    do_reset();
    @(negedge clk);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("reset_rsp_sum", bus.rsp_sum, 64'd0);
    chk("reset_rsp_cout", 64'(bus.rsp_cout), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    @(posedge clk); cyc++; #1;

    // Single isolated ops from the vector table.
    for (int v = 0; v < 5; v++) begin
      bus.req_valid = '0;
      bus.req_valid[tbl[v].rq] = 1'b1;
      set_op(tbl[v].rq, tbl[v].a, tbl[v].b, tbl[v].cin);
      step();
      chk("tbl_grant", 64'(smp_ready[tbl[v].rq]), 64'd1);
      bus.req_valid = '0;
      step();
      chk("tbl_busy_t1", 64'(smp_busy), 64'd1);
      step();
      chk("tbl_valid", 64'(smp_valid), 64'd1);
      chk("tbl_id", 64'(smp_id), 64'(tbl[v].rq));
      chk("tbl_sum", smp_sum, tbl[v].sum);
      chk("tbl_cout", 64'(smp_cout), 64'(tbl[v].cout));
      step();
      chk("tbl_valid_after", 64'(smp_valid), 64'd0);
    end

    // Contention from reset: grants 0,1,2,3,... responses trail by two cycles.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 64'(i * 100), 64'(i), 1'b0);
    bus.req_valid = '1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("cont_grant", 64'(smp_ready), 64'd1 << (k % NREQ));
      if (k >= 2) begin
        chk("cont_rsp_valid", 64'(smp_valid), 64'd1);
        chk("cont_rsp_id", 64'(smp_id), 64'((k - 2) % NREQ));
      end
    end
    bus.req_valid = '0;
    step();
    step();

    // Lock burst: bring ptr to 1, then req 1 holds the grant for three cycles.
    do_reset();
    bus.req_valid = 4'b0001;
    step();
    bus.req_valid = 4'b1011;
    bus.req_lock  = 4'b0010;
    step();
    chk("lock_g1", 64'(smp_ready), 64'b0010);
    step();
    chk("lock_g2", 64'(smp_ready), 64'b0010);
    bus.req_lock = '0;
    step();
    chk("lock_g3", 64'(smp_ready), 64'b0010);
    step();
    chk("lock_after1", 64'(smp_ready), 64'b1000);
    step();
    chk("lock_after2", 64'(smp_ready), 64'b0001);

    // Lock drop: owner 1 deasserts valid; round-robin from ptr=2 picks 3.
    bus.req_lock = 4'b0010;
    step();
    chk("drop_own", 64'(smp_ready), 64'b0010);
    bus.req_valid = 4'b1001;
    bus.req_lock  = '0;
    step();
    chk("drop_rr", 64'(smp_ready), 64'b1000);
    bus.req_valid = 4'b1011;
    step();
    chk("drop_cleared", 64'(smp_ready), 64'b0001);
    bus.req_valid = '0;
    step();
    step();

    // Reset mid-flight: the in-flight op is discarded and produces no response.
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = 4'b1100;
    rst_n = 1'b0;
    step();
    chk("rst_ready_zero", 64'(smp_ready), 64'd0);
    rst_n = 1'b1;
    bus.req_valid = '0;
    step();
    chk("rst_t2_valid", 64'(smp_valid), 64'd0);
    chk("rst_t2_sum", smp_sum, 64'd0);
    chk("rst_t2_busy", 64'(smp_busy), 64'd0);
    bus.req_valid = '1;
    step();
    chk("rst_t3_valid", 64'(smp_valid), 64'd0);
    chk("rst_first_grant", 64'(smp_ready), 64'b0001);
    bus.req_valid = '0;
    step();
    step();

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      bus.req_valid = NREQ'($urandom);
      bus.req_lock  = NREQ'($urandom & $urandom);
      for (int i = 0; i < NREQ; i++) begin
        if ($urandom_range(0, 7) == 0)
          set_op(i, '1, 64'($urandom_range(0, 2)), 1'($urandom));
        else
          set_op(i, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
      end
      step();
    end
    bus.req_valid = '0;
    bus.req_lock  = '0;
    step();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ks_adder_arbiter.md
# ks_adder_arbiter

Round-robin arbiter that shares one `ks_adder_64` among `NREQ` requesters. It instantiates the 64-bit Kogge-Stone adder between an input operand register and an output result register, issues at most one addition per cycle, and returns each result tagged with the originating requester's index. An optional per-requester lock keeps the grant for back-to-back multi-operation bursts.

## Interface
- `NREQ`, default 4: number of requesters, range 2..8.
- `IDW`, default 2: tag width, equal to clog2(`NREQ`).
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst_n` in 1: reset, synchronous and active-low.
- `req_valid` in `NREQ`: bit i is set when requester i presents an operation.
- `req_lock` in `NREQ`: bit i asks to keep the grant after the current handshake.
- `req_a` in `NREQ*64`: operand A; requester i uses bits [64i+63:64i].
- `req_b` in `NREQ*64`: operand B, packed the same way.
- `req_cin` in `NREQ`: carry-in per requester.
- `req_ready` out `NREQ`: one-hot or zero grant. Handshake i is `req_valid[i] & req_ready[i]`.
- `rsp_valid` out 1: result valid for one cycle.
- `rsp_id` out `IDW`: index of the requester that owns the result.
- `rsp_sum` out 64: result, equal to a+b+cin modulo 2^64.
- `rsp_cout` out 1: carry-out of bit 63.
- `busy` out 1: set when any operation is in flight (stage 1 or stage 2 valid).

## Operation
- State:
  - `ptr` (IDW bits): highest-priority index.
  - `lock_own` (valid bit plus IDW-bit index).
  - Stage-1 register: a, b, cin, id, valid.
  - Stage-2 register: sum, cout, id, valid.
- Grant selection is combinational each cycle:
  - If `lock_own` is valid and `req_valid[lock_own]=1`, grant `lock_own`.
  - Otherwise grant the first i with `req_valid[i]=1`, scanning ptr, ptr+1, … modulo `NREQ`.
  - If no requester is valid, `req_ready` is all zero.
- `req_ready` depends combinationally on `req_valid`. Requesters must not make `req_valid` depend on `req_ready`.
- On a handshake by requester g:
  - Capture `req_a`/`req_b`/`req_cin` slice g and id g into stage 1, and set stage-1 valid.
  - `ptr` becomes (g+1) mod `NREQ`.
  - If `req_lock[g]=1`, `lock_own` becomes {1,g}; otherwise `lock_own` is cleared.
- Lock release:
  - If the lock owner drops `req_valid`, `lock_own` is cleared in that cycle.
  - Arbitration in that same cycle uses normal round-robin.
- No handshake: stage-1 valid becomes 0. Stage-1 data may hold its value.
- Stage 2 captures `ks_adder_64` outputs driven from stage 1, plus stage-1 id and valid, every cycle.
- Outputs are driven directly from stage 2: `rsp_valid`, `rsp_id`, `rsp_sum`, `rsp_cout`.
- Results have no backpressure. Every requester must accept `rsp_valid` unconditionally.
- Results return in issue order.
- Arithmetic is plain 64-bit unsigned. Wrap-around is reported only through `rsp_cout`.

## Timing
- Handshake in cycle T gives `rsp_valid=1` in cycle T+2, with operands and id from T. Latency is fixed at 2.
- Throughput is one operation per cycle. Issuing and retiring in the same cycle is allowed and normal.
- `busy` is 1 in cycles T+1 and T+2 for an issue in T.
- Reset values while `rst_n=0` at an edge:
  - `ptr=0`, `lock_own` invalid, both stage valids 0.
  - `rsp_valid=0`, `rsp_id=0`, `rsp_sum=0`, `rsp_cout=0`, `busy=0`.
- In-flight operations are discarded and produce no response.
- `req_ready` is all zero while `rst_n=0`.
- Lock rules:
  - A locked requester that remains valid is granted every cycle, even if others are waiting.
  - Starvation under lock is the requester's responsibility.
- A requester index ≥ `NREQ` never occurs. `ptr` wraps from `NREQ-1` to 0.

## Test plan
- Single op: req 2 issues a=5, b=7, cin=1 in cycle T -> `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=13, `rsp_cout`=0 in T+2 only, with `busy` set in T+1 and T+2.
- Contention: all four valid continuously after reset -> grants 0,1,2,3,0,…, one per cycle. Responses arrive in the same order, each 2 cycles later, with no gaps.
- Wrap-around: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> `rsp_sum`=0, `rsp_cout`=1. Also a=b=64'h8000_0000_0000_0000, cin=0 -> `rsp_sum`=0, `rsp_cout`=1.
- Lock: req 1 valid with lock=1 for 3 cycles while reqs 0 and 3 are valid -> req 1 is granted 3 consecutive cycles. After lock=0 on the third handshake, the next grants are 3 then 0 (ptr=2).
- Lock drop: locked req 1 deasserts `req_valid` -> in the same cycle the grant goes round-robin from ptr, and `lock_own` is cleared.
- Reset mid-flight: issue ops in T and T+1, then assert `rst_n=0` at the edge ending T+1 -> no `rsp_valid` in T+2 or T+3, all outputs 0, and the first grant after release goes to req 0.
